// File: rtl/param_updown_counter_pkg.sv
// Shared direction constants and load-value clamp helper for param_updown_counter.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Values above the top of the count range are pinned to the top value.
  function automatic logic [32:0] clamp_to_max(input logic [32:0] value,
                                               input logic [32:0] max_val);
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/param_updown_counter_if.sv
// Control and status bundle for param_updown_counter; master drives controls, slave is the counter.
interface param_updown_counter_if #(
  parameter int WIDTH = 3
);

  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up_dn, load, load_val,
    input  q, tc, wrap
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output q, tc, wrap
  );

endinterface

// File: rtl/param_updown_counter_next_logic.sv
// Combinational next-count and terminal-count generator.
// PARAM_COUNTER_SATURATE_EN selects hold-at-boundary instead of wrap-around.
module counter_next_logic
  import counter_pkg::*;
#(
  parameter int              WIDTH   = 3,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up_dn,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q_next,
  output logic             tc
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

`ifdef PARAM_COUNTER_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_WRAP_VAL = MAX_VAL;
  localparam logic [WIDTH-1:0] DN_WRAP_VAL = '0;
`else
  localparam logic [WIDTH-1:0] UP_WRAP_VAL = '0;
  localparam logic [WIDTH-1:0] DN_WRAP_VAL = MAX_VAL;
`endif

  logic [WIDTH:0] q_inc;
  logic           at_top;
  logic           at_bot;

  // The increment is one bit wider so the modulus compare works for MODULUS == 2**WIDTH.
  always_comb begin
    q_inc  = {1'b0, q} + (WIDTH+1)'(1);
    at_top = (q == MAX_VAL);
    at_bot = (q == '0);
    tc     = en & ~load & (((up_dn == DIR_UP) & at_top) | ((up_dn == DIR_DOWN) & at_bot));
    q_next = q;
    if (load) begin
      q_next = WIDTH'(clamp_to_max(33'(load_val), 33'(MAX_VAL)));
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        q_next = (q_inc >= MOD_EXT) ? UP_WRAP_VAL : q_inc[WIDTH-1:0];
      end else begin
        q_next = at_bot ? DN_WRAP_VAL : q - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Synchronous up/down modulo-N counter with load, enable, terminal count and wrap pulse.
// PARAM_COUNTER_SATURATE_EN makes the count hold at the boundary instead of wrapping.
module param_updown_counter #(
  parameter int              WIDTH     = 3,
  parameter longint unsigned MODULUS   = 64'd1 << WIDTH,
  parameter longint unsigned RESET_VAL = 64'd0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  param_updown_counter_if.slave bus
);

  if (WIDTH < 1 || WIDTH > 32 || MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH) ||
      RESET_VAL >= MODULUS) begin : g_param_check
    $error("param_updown_counter: illegal WIDTH, MODULUS or RESET_VAL");
  end

  localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             tc;

  counter_next_logic #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q        (q_q),
    .up_dn    (bus.up_dn),
    .en       (bus.en),
    .load     (bus.load),
    .load_val (bus.load_val),
    .q_next   (q_d),
    .tc       (tc)
  );

  // tc is already masked by load and en, so it is exactly the wrap condition.
  always_comb begin
    wrap_d = tc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q    <= RESET_Q;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.tc   = tc;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: MODULUS=8 and MODULUS=6 instances, WIDTH=3.
// Expected values follow PARAM_COUNTER_SATURATE_EN when it is defined.
module tb_param_updown_counter;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   prev;

  logic [2:0] exp_t1 [9];
  logic [2:0] exp_t2 [7];
  logic [2:0] exp_t6_q [3];
  logic       exp_t6_w [3];
  logic       exp_t6_tc [3];
  logic [2:0] exp_wrap_q;

  param_updown_counter_if #(.WIDTH(3)) bus8 ();
  param_updown_counter_if #(.WIDTH(3)) bus6 ();

  param_updown_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(0)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus8)
  );

  param_updown_counter #(.WIDTH(3), .MODULUS(6), .RESET_VAL(0)) dut6 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus6)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit sel6, input logic en, input logic up_dn,
                               input logic load, input logic [2:0] load_val);
    if (sel6) begin
      bus6.en = en; bus6.up_dn = up_dn; bus6.load = load; bus6.load_val = load_val;
    end else begin
      bus8.en = en; bus8.up_dn = up_dn; bus8.load = load; bus8.load_val = load_val;
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef PARAM_COUNTER_SATURATE_EN
    exp_t1    = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    exp_t2    = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd5};
    exp_t6_q  = '{3'd7, 3'd7, 3'd7};
    exp_t6_w  = '{1'b0, 1'b1, 1'b1};
    exp_t6_tc = '{1'b0, 1'b1, 1'b1};
    exp_wrap_q = 3'd0;
`else
    exp_t1    = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    exp_t2    = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    exp_t6_q  = '{3'd7, 3'd0, 3'd1};
    exp_t6_w  = '{1'b0, 1'b1, 1'b0};
    exp_t6_tc = '{1'b0, 1'b1, 1'b0};
    exp_wrap_q = 3'd7;
`endif

    // Reset, then count down on the modulus-8 instance
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    checkOutput("rst_q8", bus8.q, 0);
    checkOutput("rst_wrap8", bus8.wrap, 0);
    checkOutput("rst_q6", bus6.q, 0);
    reset_n = 1'b1;
    prev = 0;
    for (int i = 0; i < 9; i++) begin
      checkOutput("t1_tc", bus8.tc, prev == 0);
      tick();
      checkOutput("t1_q", bus8.q, exp_t1[i]);
      checkOutput("t1_wrap", bus8.wrap, prev == 0);
      prev = exp_t1[i];
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Count up on the modulus-6 instance
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    prev = 0;
    for (int i = 0; i < 7; i++) begin
      checkOutput("t2_tc", bus6.tc, prev == 5);
      tick();
      checkOutput("t2_q", bus6.q, exp_t2[i]);
      checkOutput("t2_wrap", bus6.wrap, prev == 5);
      prev = exp_t2[i];
    end

    // Loads: clamping on modulus 6, load overriding en on modulus 8
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'd7);
    tick();
    checkOutput("t3_clamp7", bus6.q, 5);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'd6);
    tick();
    checkOutput("t3_clamp6", bus6.q, 5);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'd3);
    tick();
    checkOutput("t3_load3_m6", bus6.q, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    tick();
    checkOutput("t3_load2", bus8.q, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 3'd6);
    tick();
    checkOutput("t3_load6", bus8.q, 6);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    tick();
    checkOutput("t3_load0", bus8.q, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 3'd3);
    checkOutput("t3_tc_load", bus8.tc, 0);
    tick();
    checkOutput("t3_load3", bus8.q, 3);
    checkOutput("t3_wrap_load", bus8.wrap, 0);

    // Async reset clears a live wrap pulse between edges
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    checkOutput("t4_tc_bot", bus8.tc, 1);
    tick();
    checkOutput("t4_wrap_q", bus8.q, exp_wrap_q);
    checkOutput("t4_wrap_hi", bus8.wrap, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t4_rst_wrap", bus8.wrap, 0);
    checkOutput("t4_rst_q0", bus8.q, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    reset_n = 1'b1;

    // Count up to 4, then reset mid-cycle and hold through two edges
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput("t4_up", bus8.q, i);
    end
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t4_rst_q", bus8.q, 0);
    checkOutput("t4_rst_w", bus8.wrap, 0);
    tick();
    checkOutput("t4_hold1", bus8.q, 0);
    tick();
    checkOutput("t4_hold2", bus8.q, 0);

    // Enable low holds; direction change applies at next enabled edge
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'd5);
    reset_n = 1'b1;
    tick();
    checkOutput("t5_load5", bus8.q, 5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t5_hold_q", bus8.q, 5);
      checkOutput("t5_hold_tc", bus8.tc, 0);
      checkOutput("t5_hold_wrap", bus8.wrap, 0);
      if (i == 1) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    checkOutput("t5_dn1", bus8.q, 4);
    tick();
    checkOutput("t5_dn2", bus8.q, 3);

    // Up from 6 across the top boundary
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd6);
    tick();
    checkOutput("t6_load6", bus8.q, 6);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t6_tc", bus8.tc, exp_t6_tc[i]);
      tick();
      checkOutput("t6_q", bus8.q, exp_t6_q[i]);
      checkOutput("t6_wrap", bus8.wrap, exp_t6_w[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
